// File: rtl/rom_sample_fetcher_if.sv
`default_nettype none
// ============================================================================
//  Module   : rom_sample_fetcher_if
//  Brief    : ROM read bus plus valid/ready sample stream of the fetcher.
//  Revision : 1.0  initial release
// ============================================================================
interface rom_sample_fetcher_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] rom_a;
  logic              rom_cen;
  logic [3:0]        rom_q;
  logic [7:0]        x;
  logic              x_valid;
  logic              x_ready;
  logic              x_last;

  modport master (
    output rom_a, rom_cen, x, x_valid, x_last,
    input  rom_q, x_ready
  );

  modport slave (
    input  rom_a, rom_cen, x, x_valid, x_last,
    output rom_q, x_ready
  );
endinterface
`default_nettype wire

// File: rtl/rom_sample_fetcher.sv
`default_nettype none
// ============================================================================
//  Module   : rom_sample_fetcher
//  Brief    : Walks the nibble ROM in order, pairs nibbles (high first) into
//             8-bit samples and offers them on a valid/ready stream.
//  Revision : 1.0  initial release
// ============================================================================
module rom_sample_fetcher #(
  parameter int ADDR_W = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  rom_sample_fetcher_if.master        bus,
  output logic                        busy,
  output logic                        done
);

  localparam int               c_K_W   = ADDR_W - 1;
  localparam logic [c_K_W-1:0] c_K_MAX = '1;
  localparam logic [c_K_W-1:0] c_K_ONE = {{(c_K_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_HI = 3'd1,
    S_RD_LO = 3'd2,
    S_CAP   = 3'd3,
    S_OUT   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             r_state;
  logic [c_K_W-1:0]   r_k;
  logic [3:0]         r_hi;
  logic [ADDR_W-1:0]  r_rom_a;
  logic               r_rom_cen;
  logic [7:0]         r_x;
  logic               r_x_valid;
  logic               r_x_last;
  logic               r_busy;
  logic               r_done;
  logic [c_K_W-1:0]   w_k_inc;

  assign w_k_inc = r_k + c_K_ONE;

  // ROM controls are loaded on the edge entering each read state, so they
  // depend only on state and k and never on a live input.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_hi      <= '0;
      r_rom_a   <= '0;
      r_rom_cen <= 1'b1;
      r_x       <= '0;
      r_x_valid <= 1'b0;
      r_x_last  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_k       <= '0;
            r_rom_a   <= '0;
            r_rom_cen <= 1'b0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_state   <= S_RD_HI;
          end
        end
        S_RD_HI: begin
          r_rom_a <= {r_k, 1'b1};
          r_state <= S_RD_LO;
        end
        S_RD_LO: begin
          r_hi      <= bus.rom_q;
          r_rom_cen <= 1'b1;
          r_state   <= S_CAP;
        end
        S_CAP: begin
          r_x       <= {r_hi, bus.rom_q};
          r_x_valid <= 1'b1;
          r_x_last  <= (r_k == c_K_MAX);
          r_state   <= S_OUT;
        end
        S_OUT: begin
          if (bus.x_ready) begin
            r_x_valid <= 1'b0;
            r_x_last  <= 1'b0;
            if (r_x_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_k       <= w_k_inc;
              r_rom_a   <= {w_k_inc, 1'b0};
              r_rom_cen <= 1'b0;
              r_state   <= S_RD_HI;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rom_a   = r_rom_a;
  assign bus.rom_cen = r_rom_cen;
  assign bus.x       = r_x;
  assign bus.x_valid = r_x_valid;
  assign bus.x_last  = r_x_last;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_rom_sample_fetcher.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rom_sample_fetcher
//  Brief    : Directed self-checking bench for rom_sample_fetcher.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rom_sample_fetcher;

  localparam int ADDR_W = 10;
  localparam int N_SMP  = 512;

  logic clk;
  logic reset;
  logic start;
  logic busy;
  logic done;
  int   n_checks;
  int   n_fail;

  rom_sample_fetcher_if #(.ADDR_W(ADDR_W)) bus ();

  rom_sample_fetcher #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bus   (bus.master),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: mem[a] = a[3:0], one-cycle synchronous read
  initial bus.rom_q = 4'h0;
  always @(posedge clk) begin
    if (!bus.rom_cen) bus.rom_q <= bus.rom_a[3:0];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_x(input int k);
    logic [9:0] a;
    a = 10'(2 * k);
    return {a[3:0], a[3:0] | 4'h1};
  endfunction

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_rom_a"},   32'(bus.rom_a),   32'h0);
    check_eq({tag, "_rom_cen"}, 32'(bus.rom_cen), 32'h1);
    check_eq({tag, "_x"},       32'(bus.x),       32'h0);
    check_eq({tag, "_x_valid"}, 32'(bus.x_valid), 32'h0);
    check_eq({tag, "_x_last"},  32'(bus.x_last),  32'h0);
    check_eq({tag, "_busy"},    32'(busy),        32'h0);
    check_eq({tag, "_done"},    32'(done),        32'h0);
  endtask

  // Entered one sample point after the edge that moved the DUT into RD_HI.
  task automatic run_samples(input int n, input int stall_idx, input int stall_len,
                             input int start_idx);
    logic [9:0] a;
    for (int k = 0; k < n; k++) begin
      a = 10'(2 * k);
      check_eq("rd_hi_addr", 32'(bus.rom_a), 32'(a));
      check_eq("rd_hi_cen",  32'(bus.rom_cen), 32'h0);
      tick();
      check_eq("rd_lo_addr", 32'(bus.rom_a), 32'(a | 10'h1));
      check_eq("rd_lo_cen",  32'(bus.rom_cen), 32'h0);
      tick();
      check_eq("cap_valid", 32'(bus.x_valid), 32'h0);
      check_eq("cap_cen",   32'(bus.rom_cen), 32'h1);
      tick();
      check_eq("out_valid", 32'(bus.x_valid), 32'h1);
      check_eq("out_x",     32'(bus.x),       32'(exp_x(k)));
      check_eq("out_last",  32'(bus.x_last),  32'(k == N_SMP - 1));
      if (k == stall_idx) begin
        bus.x_ready = 1'b0;
        repeat (stall_len) begin
          tick();
          check_eq("stall_valid", 32'(bus.x_valid), 32'h1);
          check_eq("stall_x",     32'(bus.x),       32'(exp_x(k)));
          check_eq("stall_last",  32'(bus.x_last),  32'(k == N_SMP - 1));
          check_eq("stall_cen",   32'(bus.rom_cen), 32'h1);
        end
        bus.x_ready = 1'b1;
      end
      if (k == start_idx) start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("acc_valid", 32'(bus.x_valid), 32'h0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset       = 1'b1;
    start       = 1'b0;
    bus.x_ready = 1'b1;
    repeat (2) tick();
    check_reset_state("rst");
    reset = 1'b0;
    tick();
    check_eq("idle_busy", 32'(busy),        32'h0);
    check_eq("idle_cen",  32'(bus.rom_cen), 32'h1);

    // Pass A: free-flowing, start pulsed while sample 5 is offered
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("a_busy", 32'(busy), 32'h1);
    check_eq("a_done", 32'(done), 32'h0);
    run_samples(N_SMP, -1, 0, 5);
    check_eq("a_end_done", 32'(done), 32'h1);
    check_eq("a_end_busy", 32'(busy), 32'h0);
    check_eq("a_end_last", 32'(bus.x_last), 32'h0);
    tick();
    check_eq("a_hold_done", 32'(done), 32'h1);
    check_eq("a_hold_cen",  32'(bus.rom_cen), 32'h1);

    // Pass B: restart from DONE, stall sample 1, start at the final accept
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("b_done_clr", 32'(done), 32'h0);
    check_eq("b_busy",     32'(busy), 32'h1);
    run_samples(N_SMP, 1, 10, N_SMP - 1);
    check_eq("b_end_done", 32'(done), 32'h1);
    check_eq("b_end_busy", 32'(busy), 32'h0);
    tick();
    check_eq("b_ign_done", 32'(done),        32'h1);
    check_eq("b_ign_busy", 32'(busy),        32'h0);
    check_eq("b_ign_cen",  32'(bus.rom_cen), 32'h1);

    // Pass C: reset while sample 3 is held, then restart
    start = 1'b1;
    tick();
    start = 1'b0;
    run_samples(3, -1, 0, -1);
    repeat (3) tick();
    check_eq("c_pre_valid", 32'(bus.x_valid), 32'h1);
    check_eq("c_pre_x",     32'(bus.x),       32'h67);
    bus.x_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("midrst");
    bus.x_ready = 1'b1;
    tick();
    check_eq("c_idle_busy", 32'(busy), 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_samples(2, -1, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
